// File: rtl/sdfa_weight_loader.sv
// Weight loader: assembles SRAM rows from a 64-bit host stream and writes them
// row by row into the enabled 256-neuron blocks and the 80-neuron last block.
module sdfa_weight_loader #(
  parameter int WORD_W     = 64,
  parameter int ROW_W      = 3584,
  parameter int LAST_ROW_W = 1120,
  parameter int N_ROWS     = 256,
  parameter int N_BLK      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [N_BLK:0]        blk_en,
  input  logic [WORD_W-1:0]     wl_data,
  input  logic                  wl_valid,
  output logic                  wl_ready,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            cur_blk,
  output logic [7:0]            sram_addr,
  output logic [ROW_W-1:0]      sram_din,
  output logic [N_BLK*32-1:0]   sram_we_n,
  output logic [9:0]            last_we_n
);

  localparam int LANES      = 32;
  localparam int WORDS_ROW  = ROW_W / WORD_W;
  localparam int WORDS_LAST = (LAST_ROW_W + WORD_W - 1) / WORD_W;
  localparam int HALF_W     = WORD_W / 2;
  localparam int LAST_BLK   = N_BLK;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                r_state, w_stateNext;
  logic [N_BLK:0]        r_mask, w_maskNext;
  logic [3:0]            r_blk, w_blkNext;
  logic [7:0]            r_row, w_rowNext;
  logic [5:0]            r_wcnt, w_wcntNext;
  logic [ROW_W-1:0]      r_buf, w_bufNext;
  logic                  r_ready, w_readyNext;
  logic                  r_busy, w_busyNext;
  logic                  r_done, w_doneNext;
  logic [7:0]            r_addr, w_addrNext;
  logic [ROW_W-1:0]      r_din, w_dinNext;
  logic [N_BLK*32-1:0]   r_weN, w_weNNext;
  logic [9:0]            r_lastWeN, w_lastWeNNext;

  logic                  w_accept;
  logic                  w_isLast;
  logic                  w_lastWord;
  logic [11:0]           w_base;
  logic [4:0]            w_first;
  logic [4:0]            w_after;

  // Lowest enabled block at or above 'from'; bit 4 flags that one was found.
  function automatic logic [4:0] nextBlk(input logic [N_BLK:0] mask, input logic [3:0] from);
    logic [4:0] res;
    res = '0;
    for (int i = N_BLK; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  function automatic logic [N_BLK*32-1:0] laneMaskN(input logic [3:0] blk);
    logic [N_BLK*32-1:0] m;
    m = '1;
    for (int b = 0; b < N_BLK; b++) begin
      if (blk == 4'(b)) m[b*LANES +: LANES] = '0;
    end
    return m;
  endfunction

  assign w_accept   = r_ready & wl_valid;
  assign w_isLast   = (r_blk == 4'(LAST_BLK));
  assign w_lastWord = (r_wcnt == (w_isLast ? 6'(WORDS_LAST - 1) : 6'(WORDS_ROW - 1)));
  assign w_base     = 12'(r_wcnt) * 12'(WORD_W);
  assign w_first    = nextBlk(blk_en, 4'd0);
  assign w_after    = nextBlk(r_mask, r_blk + 4'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Every output is computed one cycle ahead so the ports come straight from flops.
  always_comb begin
    w_stateNext   = r_state;
    w_maskNext    = r_mask;
    w_blkNext     = r_blk;
    w_rowNext     = r_row;
    w_wcntNext    = r_wcnt;
    w_bufNext     = r_buf;
    w_readyNext   = 1'b0;
    w_busyNext    = r_busy;
    w_doneNext    = 1'b0;
    w_addrNext    = r_addr;
    w_dinNext     = r_din;
    w_weNNext     = '1;
    w_lastWeNNext = '1;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_maskNext = blk_en;
          w_busyNext = 1'b1;
          if (!w_first[4]) begin
            w_stateNext = DONE;
          end else begin
            w_blkNext   = w_first[3:0];
            w_rowNext   = '0;
            w_wcntNext  = '0;
            w_readyNext = 1'b1;
            w_stateNext = FILL;
          end
        end
      end

      FILL: begin
        w_readyNext = 1'b1;
        if (w_accept) begin
          w_bufNext[w_base +: HALF_W] = wl_data[HALF_W-1:0];
          // The last block's final word only carries 32 meaningful bits.
          if (!(w_isLast && w_lastWord))
            w_bufNext[w_base + 12'(HALF_W) +: HALF_W] = wl_data[WORD_W-1:HALF_W];
          w_wcntNext = r_wcnt + 6'd1;
          if (w_lastWord) begin
            w_readyNext = 1'b0;
            w_addrNext  = r_row;
            w_dinNext   = w_bufNext;
            if (w_isLast) w_lastWeNNext = '0;
            else          w_weNNext     = laneMaskN(r_blk);
            w_stateNext = WRITE;
          end
        end
      end

      WRITE: begin
        w_wcntNext = '0;
        if (r_row != 8'(N_ROWS - 1)) begin
          w_rowNext   = r_row + 8'd1;
          w_readyNext = 1'b1;
          w_stateNext = FILL;
        end else if (w_after[4]) begin
          w_blkNext   = w_after[3:0];
          w_rowNext   = '0;
          w_readyNext = 1'b1;
          w_stateNext = FILL;
        end else begin
          w_doneNext  = 1'b1;
          w_busyNext  = 1'b0;
          w_stateNext = DONE;
        end
      end

      DONE: begin
        // An empty mask arrives here with done still low and raises it now.
        if (r_done) begin
          w_stateNext = IDLE;
        end else begin
          w_doneNext = 1'b1;
          w_busyNext = 1'b0;
        end
      end

      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mask    <= '0;
      r_blk     <= '0;
      r_row     <= '0;
      r_wcnt    <= '0;
      r_buf     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_weN     <= '1;
      r_lastWeN <= '1;
    end else begin
      r_mask    <= w_maskNext;
      r_blk     <= w_blkNext;
      r_row     <= w_rowNext;
      r_wcnt    <= w_wcntNext;
      r_buf     <= w_bufNext;
      r_ready   <= w_readyNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_addr    <= w_addrNext;
      r_din     <= w_dinNext;
      r_weN     <= w_weNNext;
      r_lastWeN <= w_lastWeNNext;
    end
  end

  assign wl_ready  = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cur_blk   = r_blk;
  assign sram_addr = r_addr;
  assign sram_din  = r_din;
  assign sram_we_n = r_weN;
  assign last_we_n = r_lastWeN;

endmodule

// File: tb/tb_sdfa_weight_loader.sv
// Bench for sdfa_weight_loader: randomized host streams checked against a
// row-assembly model of the expected block/row write sequence.
module tb_sdfa_weight_loader;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [8:0]    blk_en;
  logic [63:0]   wl_data;
  logic          wl_valid;
  logic          wl_ready;
  logic          busy;
  logic          done;
  logic [3:0]    cur_blk;
  logic [7:0]    sram_addr;
  logic [3583:0] sram_din;
  logic [255:0]  sram_we_n;
  logic [9:0]    last_we_n;

  int checks = 0;
  int errors = 0;

  sdfa_weight_loader dut (
    .clk(clk), .rstn(rstn), .start(start), .blk_en(blk_en),
    .wl_data(wl_data), .wl_valid(wl_valid), .wl_ready(wl_ready),
    .busy(busy), .done(done), .cur_blk(cur_blk), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_we_n(sram_we_n), .last_we_n(last_we_n)
  );

  always #5 clk = ~clk;

  // Drives one load and checks every observed write against rows rebuilt from the
  // words actually accepted. mode 0: random words, 1: {B0,k}, 2: random with the
  // 18th last-block word fixed. Aborts with rstn low at (abortRow, abortWords) of
  // the first enabled block when abortRow >= 0.
  task automatic runLoad(input logic [8:0] mask, input int validPct, input int mode,
                         input int extraStartAt, input int abortRow, input int abortWords,
                         input int limit, output int words, output int writes,
                         output int doneCycle, output bit aborted);
    int            blocks[$];
    logic [63:0]   rowWords[$];
    int            expIdx, expRow, n, eb, fj;
    logic [63:0]   w;
    logic [3583:0] expDin, actDin;
    logic [255:0]  expWe;
    logic [9:0]    expLast;
    bit            v;
    words = 0; writes = 0; doneCycle = -1; aborted = 0;
    expIdx = 0; expRow = 0;
    for (int b = 0; b < 9; b++) if (mask[b]) blocks.push_back(b);
    @(negedge clk);
    blk_en = mask; start = 1'b1; wl_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (c > 0) @(negedge clk);
      start  = (c == extraStartAt);
      blk_en = (c == extraStartAt) ? ~mask : mask;
      if (sram_we_n !== '1 || last_we_n !== '1) begin
        writes++;
        checks++;
        if (expIdx >= blocks.size()) begin
          errors++;
          $display("[TB] FAIL unexpected_write: addr %0d we_n %h last_we_n %h, required no write", sram_addr, sram_we_n, last_we_n);
        end else begin
          eb = blocks[expIdx];
          n = (eb == 8) ? 18 : 56;
          expWe = '1; expLast = '1;
          if (eb == 8) expLast = '0;
          else expWe[eb*32 +: 32] = '0;
          if (sram_we_n !== expWe || last_we_n !== expLast) begin
            errors++;
            $display("[TB] FAIL write_lanes: we_n %h last %h, required %h last %h", sram_we_n, last_we_n, expWe, expLast);
          end
          checks++;
          if (sram_addr !== 8'(expRow)) begin
            errors++;
            $display("[TB] FAIL write_addr: got %0d, required %0d", sram_addr, expRow);
          end
          checks++;
          if (cur_blk !== 4'(eb) || wl_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_blk_ready: cur_blk %0d ready %b, required %0d ready 0", cur_blk, wl_ready, eb);
          end
          checks++;
          if (rowWords.size() != n) begin
            errors++;
            $display("[TB] FAIL words_per_row: got %0d, required %0d (blk %0d row %0d)", rowWords.size(), n, eb, expRow);
          end else begin
            checks++;
            expDin = '0;
            actDin = sram_din;
            for (int j = 0; j < n - 1; j++) expDin[j*64 +: 64] = rowWords[j];
            if (eb == 8) begin
              expDin[1119:1088] = rowWords[17][31:0];
              actDin[3583:1120] = '0;
            end else begin
              expDin[3583:3520] = rowWords[55];
            end
            if (actDin !== expDin) begin
              errors++;
              fj = 0;
              for (int j = 55; j >= 0; j--) if (actDin[j*64 +: 64] !== expDin[j*64 +: 64]) fj = j;
              $display("[TB] FAIL row_data blk %0d row %0d word %0d: got %h, required %h", eb, expRow, fj, actDin[fj*64 +: 64], expDin[fj*64 +: 64]);
            end
          end
          rowWords.delete();
          expRow++;
          if (expRow == 256) begin
            expRow = 0;
            expIdx++;
          end
        end
      end
      if (done === 1'b1) begin
        doneCycle = c;
        checks++;
        if (busy !== 1'b0 || wl_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL done_status: busy %b ready %b, required 0 0", busy, wl_ready);
        end
        break;
      end
      if (abortRow >= 0 && expIdx == 0 && expRow == abortRow && rowWords.size() == abortWords) begin
        rstn = 1'b0;
        wl_valid = 1'b0;
        aborted = 1;
        break;
      end
      v = ($urandom_range(0, 99) < validPct);
      if (mode == 1) w = {32'hB0, 32'(words)};
      else if (mode == 2 && expIdx < blocks.size() && blocks[expIdx] == 8 && rowWords.size() == 17)
        w = 64'hDEAD_BEEF_1234_5678;
      else w = {$urandom, $urandom};
      wl_valid = v;
      wl_data  = w;
      if (v && wl_ready === 1'b1) begin
        words++;
        rowWords.push_back(w);
      end
    end
    wl_valid = 1'b0;
    start = 1'b0;
    blk_en = mask;
    if (doneCycle < 0 && !aborted) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_timeout: no done within %0d cycles, required done", limit);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; blk_en = '0; wl_valid = 1'b0; wl_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (wl_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b, required 0", wl_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
    checks++; if (cur_blk !== 4'd0) begin errors++; $display("[TB] FAIL reset_cur_blk: got %0d, required 0", cur_blk); end
    checks++; if (sram_addr !== 8'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d, required 0", sram_addr); end
    checks++; if (sram_din !== '0) begin errors++; $display("[TB] FAIL reset_din: got nonzero, required 0"); end
    checks++; if (sram_we_n !== '1) begin errors++; $display("[TB] FAIL reset_we_n: got %h, required all ones", sram_we_n); end
    checks++; if (last_we_n !== '1) begin errors++; $display("[TB] FAIL reset_last_we_n: got %h, required 3ff", last_we_n); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block;
    int words, writes, dc; bit ab;
    runLoad(9'h001, 100, 1, 1000, -1, 0, 20000, words, writes, dc, ab);
    checks++; if (dc != 14592) begin errors++; $display("[TB] FAIL single_done_cycle: got %0d, required 14592", dc); end
    checks++; if (writes != 256) begin errors++; $display("[TB] FAIL single_writes: got %0d, required 256", writes); end
    checks++; if (words != 14336) begin errors++; $display("[TB] FAIL single_words: got %0d, required 14336", words); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: done %b busy %b, required 0 0", done, busy); end
  endtask

  task automatic test_last_block;
    int words, writes, dc; bit ab;
    runLoad(9'h100, 100, 2, -1, -1, 0, 8000, words, writes, dc, ab);
    checks++; if (dc != 4864) begin errors++; $display("[TB] FAIL last_done_cycle: got %0d, required 4864", dc); end
    checks++; if (writes != 256) begin errors++; $display("[TB] FAIL last_writes: got %0d, required 256", writes); end
    checks++; if (words != 4608) begin errors++; $display("[TB] FAIL last_words: got %0d, required 4608", words); end
  endtask

  task automatic test_skip_backpressure;
    int words, writes, dc; bit ab;
    runLoad(9'h104, 60, 0, -1, -1, 0, 60000, words, writes, dc, ab);
    checks++; if (writes != 512) begin errors++; $display("[TB] FAIL skip_writes: got %0d, required 512", writes); end
    checks++; if (words != 18944) begin errors++; $display("[TB] FAIL skip_words: got %0d, required 18944", words); end
  endtask

  task automatic test_empty_mask;
    int words, writes, dc; bit ab;
    runLoad(9'h000, 100, 0, -1, -1, 0, 20, words, writes, dc, ab);
    checks++; if (dc != 1) begin errors++; $display("[TB] FAIL empty_done_cycle: got %0d, required 1", dc); end
    checks++; if (writes != 0 || words != 0) begin errors++; $display("[TB] FAIL empty_activity: writes %0d words %0d, required 0 0", writes, words); end
  endtask

  task automatic test_abort;
    int words, writes, dc; bit ab;
    runLoad(9'h001, 100, 0, -1, 5, 30, 2000, words, writes, dc, ab);
    checks++; if (!ab || writes != 5) begin errors++; $display("[TB] FAIL abort_point: aborted %b writes %0d, required 1 5", ab, writes); end
    #1;
    checks++;
    if (sram_we_n !== '1 || last_we_n !== '1 || wl_ready !== 1'b0 || busy !== 1'b0 || cur_blk !== 4'd0 || sram_addr !== 8'd0) begin
      errors++;
      $display("[TB] FAIL abort_reset_state: we_n_low %b last %h ready %b busy %b blk %0d addr %0d, required all idle", sram_we_n !== '1, last_we_n, wl_ready, busy, cur_blk, sram_addr);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (sram_we_n !== '1 || last_we_n !== '1) begin errors++; $display("[TB] FAIL abort_no_write: enables low during reset, required all ones"); end
    end
    rstn = 1'b1;
    @(negedge clk);
    runLoad(9'h001, 100, 0, -1, 2, 0, 500, words, writes, dc, ab);
    checks++; if (!ab || writes != 2) begin errors++; $display("[TB] FAIL restart_writes: aborted %b writes %0d, required 1 2", ab, writes); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; blk_en = '0; wl_valid = 1'b0; wl_data = '0;
    test_reset();
    test_empty_mask();
    test_single_block();
    test_last_block();
    test_skip_backpressure();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
